// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the RV32I execute stage and its ALU.
// No logic lives here; widths and encodings only.
package execute_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REGADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic                 reg_write;
        logic                 mem_write;
        logic [1:0]           result_src;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      write_data;
        logic [XLEN-1:0]      pc_plus4;
        logic [REGADDR_W-1:0] rd;
    } ex_mem_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding selects, redirect and EX/MEM outputs of the execute stage.
// master drives the E-side inputs; slave is the execute stage itself.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic                 RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [2:0]           ALUControlE;
    logic [XLEN-1:0]      RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [REGADDR_W-1:0] RDE;
    logic [1:0]           ForwardAE, ForwardBE;
    logic [XLEN-1:0]      ResultW;

    logic                 PCSrcE;
    logic [XLEN-1:0]      PCTargetE;
    logic                 RegWriteM, MemWriteM;
    logic [1:0]           ResultSrcM;
    logic [XLEN-1:0]      ALUResultM, WriteDataM, PCPlus4M;
    logic [REGADDR_W-1:0] RDM;

    modport master (
        output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RDM
    );

    modport slave (
        input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RDM
    );

endinterface

// File: rtl/execute_stage_alu.sv
// RV32I ALU subset (ADD/SUB/AND/OR/SLT); purely combinational, zero latency.
// No backpressure: result follows inputs; unused op codes yield zero.
module alu
    import execute_stage_pkg::*;
(
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, BEQ/JAL redirect (same cycle), EX/MEM register (1 cycle).
// No backpressure: the EX/MEM register advances every clock; bubbles arrive as zero control.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    execute_stage_if.slave ex
);

    ex_mem_t         ex_mem_d, ex_mem_q;
    logic [XLEN-1:0] src_a_e, write_data_e, src_b_e, alu_result_e;
    logic            zero_e;

    // MEM forwarding reads the register before this edge overwrites it
    always_comb begin
        src_a_e = ex.RD1E;
        case (ex.ForwardAE)
            FWD_WB:  src_a_e = ex.ResultW;
            FWD_MEM: src_a_e = ex_mem_q.alu_result;
            default: src_a_e = ex.RD1E;
        endcase

        write_data_e = ex.RD2E;
        case (ex.ForwardBE)
            FWD_WB:  write_data_e = ex.ResultW;
            FWD_MEM: write_data_e = ex_mem_q.alu_result;
            default: write_data_e = ex.RD2E;
        endcase
    end

    assign src_b_e = ex.ALUSrcE ? ex.ImmExtE : write_data_e;

    alu u_alu (
        .SrcA       (src_a_e),
        .SrcB       (src_b_e),
        .ALUControl (ex.ALUControlE),
        .Result     (alu_result_e),
        .Zero       (zero_e)
    );

    assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
    assign ex.PCSrcE    = (ex.BranchE & zero_e) | ex.JumpE;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = ex.RegWriteE;
        ex_mem_d.mem_write  = ex.MemWriteE;
        ex_mem_d.result_src = ex.ResultSrcE;
        ex_mem_d.alu_result = alu_result_e;
        ex_mem_d.write_data = write_data_e;
        ex_mem_d.pc_plus4   = ex.PCPlus4E;
        ex_mem_d.rd         = ex.RDE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ex.RegWriteM  = ex_mem_q.reg_write;
    assign ex.MemWriteM  = ex_mem_q.mem_write;
    assign ex.ResultSrcM = ex_mem_q.result_src;
    assign ex.ALUResultM = ex_mem_q.alu_result;
    assign ex.WriteDataM = ex_mem_q.write_data;
    assign ex.PCPlus4M   = ex_mem_q.pc_plus4;
    assign ex.RDM        = ex_mem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Execute stage bench: directed cases plus random traffic against a behavioural model.
// Expected M values are held as the model's notion of "last instruction's results".
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_if dif ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .ex  (dif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return dif.ResultW;
        if (sel == 2'd2) return m_alu;
        return rf;
    endfunction

    task automatic model_reset();
        m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
        m_rw = 1'b0; m_mw = 1'b0; m_rs = '0;
    endtask

    task automatic check_m();
        check_eq("RegWriteM",  {31'b0, dif.RegWriteM},  {31'b0, m_rw});
        check_eq("MemWriteM",  {31'b0, dif.MemWriteM},  {31'b0, m_mw});
        check_eq("ResultSrcM", {30'b0, dif.ResultSrcM}, {30'b0, m_rs});
        check_eq("ALUResultM", dif.ALUResultM, m_alu);
        check_eq("WriteDataM", dif.WriteDataM, m_wd);
        check_eq("PCPlus4M",   dif.PCPlus4M,   m_pc4);
        check_eq("RDM",        {27'b0, dif.RDM}, {27'b0, m_rd});
    endtask

    task automatic clear_inputs();
        dif.RegWriteE = 0; dif.MemWriteE = 0; dif.BranchE = 0; dif.JumpE = 0;
        dif.ALUSrcE = 0; dif.ResultSrcE = 0; dif.ALUControlE = 0;
        dif.RD1E = 0; dif.RD2E = 0; dif.ImmExtE = 0; dif.PCE = 0; dif.PCPlus4E = 0;
        dif.RDE = 0; dif.ForwardAE = 0; dif.ForwardBE = 0; dif.ResultW = 0;
    endtask

    // One instruction: check redirect mid-cycle, clock it, check the M register.
    task automatic cycle();
        logic [31:0] a, wd, b, r;
        logic        taken;
        #1;
        a     = fwd(dif.ForwardAE, dif.RD1E);
        wd    = fwd(dif.ForwardBE, dif.RD2E);
        b     = dif.ALUSrcE ? dif.ImmExtE : wd;
        r     = ref_alu(dif.ALUControlE, a, b);
        taken = dif.JumpE || (dif.BranchE && (r == 32'd0));
        check_eq("PCSrcE",    {31'b0, dif.PCSrcE}, {31'b0, taken});
        check_eq("PCTargetE", dif.PCTargetE, dif.PCE + dif.ImmExtE);
        @(posedge clk);
        m_alu = r; m_wd = wd; m_pc4 = dif.PCPlus4E; m_rd = dif.RDE;
        m_rw = dif.RegWriteE; m_mw = dif.MemWriteE; m_rs = dif.ResultSrcE;
        #1;
        check_m();
    endtask

    // Called just after a rising edge: reset lands and is checked before the next edge.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        check_m();
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        dif.RegWriteE = 1; dif.MemWriteE = 1; dif.ResultSrcE = 2'd3; dif.RD1E = 32'h55;
        dif.PCPlus4E = 32'h44; dif.RDE = 5'd7; dif.RD2E = 32'h99;
        repeat (2) @(posedge clk);
        #1 check_m();
        rst = 1'b1;

        clear_inputs();
        dif.RDE = 5'd5; dif.RegWriteE = 1;
        cycle();
        check_eq("rst_rel_RDM", {27'b0, dif.RDM}, 32'd5);

        clear_inputs();
        dif.RD1E = 32'd7; dif.ImmExtE = 32'hFFFF_FFFD; dif.ALUSrcE = 1; dif.ALUControlE = 3'b000;
        cycle();
        check_eq("add_imm", dif.ALUResultM, 32'd4);

        clear_inputs();
        dif.RD1E = 32'd3; dif.RD2E = 32'd5; dif.ALUControlE = 3'b001;
        cycle();
        check_eq("sub", dif.ALUResultM, 32'hFFFF_FFFE);

        dif.RD1E = 32'hFFFF_FFFF; dif.RD2E = 32'd1; dif.ALUControlE = 3'b101;
        cycle();
        check_eq("slt", dif.ALUResultM, 32'd1);

        clear_inputs();
        dif.RD1E = 32'h10; dif.ALUControlE = 3'b000;
        cycle();
        dif.RD1E = 0; dif.RD2E = 0; dif.ResultW = 32'h20; dif.ForwardAE = 2'b10; dif.ForwardBE = 2'b01;
        cycle();
        check_eq("fwd_alu", dif.ALUResultM, 32'h30);
        check_eq("fwd_wd",  dif.WriteDataM, 32'h20);

        dif.ForwardAE = 2'b11; dif.ForwardBE = 2'b00; dif.RD1E = 32'd7; dif.RD2E = 32'd1;
        cycle();
        check_eq("fwd_rsvd", dif.ALUResultM, 32'd8);

        clear_inputs();
        dif.BranchE = 1; dif.RD1E = 32'd9; dif.RD2E = 32'd9; dif.ALUControlE = 3'b001;
        dif.PCE = 32'h100; dif.ImmExtE = 32'h20;
        cycle();
        check_eq("beq_taken",  {31'b0, dif.PCSrcE}, 32'd1);
        check_eq("beq_target", dif.PCTargetE, 32'h120);
        dif.RD2E = 32'd8;
        cycle();
        check_eq("beq_not", {31'b0, dif.PCSrcE}, 32'd0);

        clear_inputs();
        dif.JumpE = 1; dif.PCE = 32'hFFFF_FFF0; dif.ImmExtE = 32'h20; dif.PCPlus4E = 32'hFFFF_FFF4;
        dif.RegWriteE = 1; dif.RDE = 5'd1;
        cycle();
        check_eq("jal_src",    {31'b0, dif.PCSrcE}, 32'd1);
        check_eq("jal_target", dif.PCTargetE, 32'h10);
        check_eq("jal_pc4",    dif.PCPlus4M, 32'hFFFF_FFF4);

        async_reset();

        for (int i = 0; i < 400; i++) begin
            dif.RegWriteE   = 1'($urandom);
            dif.MemWriteE   = 1'($urandom);
            dif.BranchE     = 1'($urandom);
            dif.JumpE       = ($urandom_range(0, 3) == 0);
            dif.ALUSrcE     = 1'($urandom);
            dif.ResultSrcE  = 2'($urandom);
            dif.ALUControlE = 3'($urandom);
            dif.RD1E        = $urandom;
            dif.RD2E        = ($urandom_range(0, 3) == 0) ? dif.RD1E : $urandom;
            dif.ImmExtE     = $urandom;
            dif.PCE         = $urandom;
            dif.PCPlus4E    = dif.PCE + 32'd4;
            dif.RDE         = 5'($urandom);
            dif.ForwardAE   = 2'($urandom);
            dif.ForwardBE   = 2'($urandom);
            dif.ResultW     = $urandom;
            cycle();
            if (i % 97 == 50) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage RV32I pipeline. Sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Selects forwarded operands and runs the ALU.
- Resolves branches and JAL, producing the redirect to fetch.
- Registers results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REGADDR_W, 5, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  in  1 each  control bits from the ID/EX register.
- ResultSrcE  in  2  writeback select.
- ALUControlE  in  3  ALU operation.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  XLEN each  operands, immediate and PCs.
- RDE  in  REGADDR_W  destination register.
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback-stage result, used for forwarding.
- PCSrcE  out  1  combinational redirect request to fetch.
- PCTargetE  out  XLEN  combinational branch/JAL target.
- RegWriteM, MemWriteM  out  1 each  registered control bits.
- ResultSrcM  out  2  registered writeback select.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  registered results.
- RDM  out  REGADDR_W  registered destination register.

Behaviour:
- Reset:
  - While rst=0, asynchronously clear all M outputs to 0.
  - Registers reload on the first rising clk edge after rst returns to 1.
  - Reset mid-operation discards the in-flight instruction; no partial state is kept.
- Forwarding muxes, operand A (SrcAE) from ForwardAE:
  - 00 selects RD1E.
  - 01 selects ResultW.
  - 10 selects ALUResultM, i.e. this block's own registered output.
  - 11 is reserved and selects RD1E.
- Forwarding mux for B (WriteDataE) uses ForwardBE with the same encoding, applied to RD2E.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, combinational. All arithmetic wraps modulo 2^32 with no overflow flag.
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 101 SLT: signed compare, result is 32'h1 or 32'h0.
  - Any other code gives result 0.
- ZeroE = (ALUResult == 0).
- PCTargetE = PCE + ImmExtE, wrapping.
- PCSrcE = (BranchE & ZeroE) | JumpE. Supports BEQ and JAL only; JALR is out of scope.
- Latency: PCSrcE and PCTargetE are available in the same cycle, with no register. All M outputs appear exactly 1 cycle after the E inputs.
- On each rising clk edge (rst=1):
  - RegWriteM, MemWriteM, ResultSrcM, RDM and PCPlus4M load their E counterparts.
  - ALUResultM loads the ALU result.
  - WriteDataM loads the forwarded WriteDataE, not the raw RD2E.
- No stall or flush inputs: the register advances every cycle.
- The block applies no gating to control bits. Bubbles arrive as all-zero control from upstream.
- Back-to-back dependent instructions with ForwardAE=10 use the value currently in ALUResultM before it is overwritten at the edge.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward-select constants: FWD_RF, FWD_WB, FWD_MEM.
  - XLEN.
- One sub-module, alu: inputs SrcA, SrcB, ALUControl; outputs Result, Zero. Purely combinational.
- Forwarding muxes, target adder and the EX/MEM register stay in execute_stage.

Test Plan:
- Reset: hold rst=0 with nonzero inputs -> all M outputs 0. Release rst, present RDE=5, RegWriteE=1, then one edge -> RDM=5, RegWriteM=1.
- ADD with immediate: RD1E=7, ImmExtE=32'hFFFFFFFD, ALUSrcE=1, ALUControlE=000 -> ALUResultM=4 after 1 edge. SUB 3-5 -> 32'hFFFFFFFE. SLT with -1 vs 1 -> 1.
- Forwarding: ALUResultM=32'h10, ResultW=32'h20, RD1E=0, RD2E=0, ForwardAE=10, ForwardBE=01, ADD -> ALUResultM=32'h30 and WriteDataM=32'h20. With ForwardAE=11 -> RD1E is used.
- BEQ taken: BranchE=1, RD1E=RD2E=9, SUB, PCE=32'h100, ImmExtE=32'h20 -> same cycle PCSrcE=1, PCTargetE=32'h120. With RD2E=8 -> PCSrcE=0.
- JAL: JumpE=1, BranchE=0, PCE=32'hFFFFFFF0, ImmExtE=32'h20 -> PCSrcE=1, PCTargetE=32'h10 (wrap). PCPlus4E=32'hFFFFFFF4 -> PCPlus4M matches after 1 edge.
- Reset mid-stream: assert rst asynchronously between edges while M outputs are nonzero -> outputs clear immediately without waiting for clk.
